// File: rtl/alu_host_sequencer.sv
// alu_host_sequencer: host-side initiator for the serial-operand ALU.
// Takes one request, resets the ALU, streams the operand bytes, waits for END,
// collects the 1- or 2-byte result and returns it on a valid/ready response.
// Optional build macro ALU_SEQ_CHECK_EN adds a result cross-check (status 11)
// and a saturating err_cnt output.
//
// state    | meaning
// IDLE     | ready for a request, ALU out of reset
// ARST     | one-cycle ALU reset pulse
// LD_A     | BEGIN high, first operand byte on inbus
// LD_B     | second operand byte on inbus
// LD_C     | divisor byte on inbus (DIV only)
// WAIT_END | waiting for END, timeout counter running
// CAPT2    | capture low byte of a 2-byte result
// RESP     | response held until accepted
module alu_host_sequencer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_status,
  output logic        alu_reset,
  output logic        alu_begin,
  output logic [1:0]  alu_op,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
`ifdef ALU_SEQ_CHECK_EN
  , output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARST, S_LD_A, S_LD_B, S_LD_C, S_WAIT_END, S_CAPT2, S_RESP
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_TMO  = 2'b01;
  localparam logic [1:0] ST_DIV0 = 2'b10;
  // Counter is cleared on entry, so the last allowed WAIT_END cycle sees TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [15:0]       a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_d, resp_valid_d, alu_reset_d, alu_begin_d;
  logic [15:0]       resp_data_d;
  logic [1:0]        resp_status_d, alu_op_d;
  logic [7:0]        alu_inbus_d;

`ifdef ALU_SEQ_CHECK_EN
  localparam logic [1:0] ST_CHK = 2'b11;
  logic [15:0] exp_q, exp_d, exp_calc;
  logic [7:0]  err_d;

  // Reference result of the incoming request, latched alongside the operands.
  always_comb begin
    exp_calc = '0;
    case (req_op)
      OP_ADD: exp_calc = {8'h00, req_a[7:0] + req_b};
      OP_SUB: exp_calc = {8'h00, req_a[7:0] - req_b};
      OP_MUL: exp_calc = 16'(req_a[7:0]) * 16'(req_b);
      OP_DIV: if (req_b != 8'h00)
                exp_calc = {8'(req_a / 16'(req_b)), 8'(req_a % 16'(req_b))};
      default: exp_calc = '0;
    endcase
  end
`endif

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready;
    resp_valid_d  = resp_valid;
    resp_data_d   = resp_data;
    resp_status_d = resp_status;
    alu_reset_d   = alu_reset;
    alu_begin_d   = alu_begin;
    alu_op_d      = alu_op;
    alu_inbus_d   = alu_inbus;
`ifdef ALU_SEQ_CHECK_EN
    exp_d         = exp_q;
    err_d         = err_cnt;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        alu_reset_d = 1'b0;
        if (req_valid && req_ready) begin
          op_d        = req_op;
          a_d         = req_a;
          b_d         = req_b;
          req_ready_d = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
          exp_d       = exp_calc;
`endif
          if (req_op == OP_DIV && req_b == 8'h00) begin
            state_d       = S_RESP;
            resp_valid_d  = 1'b1;
            resp_data_d   = '0;
            resp_status_d = ST_DIV0;
          end else begin
            state_d     = S_ARST;
            alu_reset_d = 1'b1;
          end
        end
      end
      S_ARST: begin
        state_d     = S_LD_A;
        alu_reset_d = 1'b0;
        alu_begin_d = 1'b1;
        alu_op_d    = op_q;
        alu_inbus_d = (op_q == OP_DIV) ? a_q[15:8] : a_q[7:0];
      end
      S_LD_A: begin
        state_d     = S_LD_B;
        alu_begin_d = 1'b0;
        alu_inbus_d = (op_q == OP_DIV) ? a_q[7:0] : b_q;
      end
      S_LD_B: begin
        cnt_d = '0;
        if (op_q == OP_DIV) begin
          state_d     = S_LD_C;
          alu_inbus_d = b_q;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      S_LD_C: begin
        state_d = S_WAIT_END;
        cnt_d   = '0;
      end
      S_WAIT_END: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_end) begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              state_d       = S_RESP;
              resp_valid_d  = 1'b1;
              resp_data_d   = {8'h00, alu_outbus};
              resp_status_d = ST_OK;
            end
            OP_MUL, OP_DIV: begin
              state_d     = S_CAPT2;
              resp_data_d = {alu_outbus, resp_data[7:0]};
            end
          endcase
        end else if (cnt_q == TMO_LAST) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_data_d   = '0;
          resp_status_d = ST_TMO;
          alu_reset_d   = 1'b1;
        end
      end
      S_CAPT2: begin
        state_d       = S_RESP;
        resp_valid_d  = 1'b1;
        resp_data_d   = {resp_data[15:8], alu_outbus};
        resp_status_d = ST_OK;
      end
      S_RESP: begin
        alu_reset_d = 1'b0;
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ALU_SEQ_CHECK_EN
    // An otherwise-good result that disagrees with the reference is flagged once.
    if (state_d == S_RESP && (state_q == S_WAIT_END || state_q == S_CAPT2) &&
        resp_status_d == ST_OK && resp_data_d != exp_q) begin
      resp_status_d = ST_CHK;
      if (err_cnt != 8'hFF) err_d = err_cnt + 8'd1;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= '0;
      alu_reset   <= 1'b1;
      alu_begin   <= 1'b0;
      alu_op      <= '0;
      alu_inbus   <= '0;
`ifdef ALU_SEQ_CHECK_EN
      exp_q       <= '0;
      err_cnt     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
      resp_status <= resp_status_d;
      alu_reset   <= alu_reset_d;
      alu_begin   <= alu_begin_d;
      alu_op      <= alu_op_d;
      alu_inbus   <= alu_inbus_d;
`ifdef ALU_SEQ_CHECK_EN
      exp_q       <= exp_d;
      err_cnt     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Testbench for alu_host_sequencer: directed cases plus randomized requests,
// with a behavioural ALU model on the serial bus and an arithmetic reference
// for the expected response.
module tb_alu_host_sequencer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [7:0]  req_b;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_status;
  logic        alu_reset, alu_begin;
  logic [1:0]  alu_op;
  logic [7:0]  alu_inbus, alu_outbus;
  logic        alu_end;
`ifdef ALU_SEQ_CHECK_EN
  logic [7:0]  err_cnt;
  int          exp_err = 0;
`endif

  int tests = 0;
  int fails = 0;

  alu_host_sequencer #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_status(resp_status),
    .alu_reset(alu_reset), .alu_begin(alu_begin), .alu_op(alu_op),
    .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_end(alu_end)
`ifdef ALU_SEQ_CHECK_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected response straight from the operation definitions.
  function automatic void ref_model(input logic [1:0] op, input logic [15:0] a,
                                    input logic [7:0] b, output logic [15:0] d,
                                    output logic [1:0] st);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    st = 2'd0;
    d  = '0;
    case (op)
      2'd0: d = 16'((ai % 256 + bi) % 256);
      2'd1: d = 16'((ai % 256 - bi + 256) % 256);
      2'd2: d = 16'((ai % 256) * bi);
      default: begin
        if (bi == 0) st = 2'd2;
        else d = 16'(((ai / bi) % 256) * 256 + (ai % bi));
      end
    endcase
  endfunction

  // Serial ALU: rebuilds the operands from the bytes it saw on inbus.
  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2);
    int x, y, dvd;
    x = int'(b0);
    y = int'(b1);
    case (op)
      2'd0: return 16'((x + y) % 256);
      2'd1: return 16'((x - y + 256) % 256);
      2'd2: return 16'(x * y);
      default: begin
        dvd = x * 256 + y;
        if (b2 == 8'h00) return 16'h0000;
        return 16'(((dvd / int'(b2)) % 256) * 256 + dvd % int'(b2));
      end
    endcase
  endfunction

  // mode: 0 normal, 1 ALU never ends, 2 ALU corrupts result, 3 reset during WAIT_END
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                        input int lat, input int stall, input int mode);
    logic [7:0]  by [3];
    logic [7:0]  exp_by [3];
    logic [15:0] exp_data, res;
    logic [1:0]  exp_st;
    int n, nb;
    nb = (op == 2'd3) ? 3 : 2;
    exp_by[0] = (op == 2'd3) ? a[15:8] : a[7:0];
    exp_by[1] = (op == 2'd3) ? a[7:0] : b;
    exp_by[2] = b;
    by[2] = 8'h00;
    ref_model(op, a, b, exp_data, exp_st);
    if (mode == 1) begin exp_data = '0; exp_st = 2'd1; end
    if (mode == 2) exp_data[0] = ~exp_data[0];

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("req_ready_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_a = 16'($urandom); req_b = 8'($urandom);
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);

    if (exp_st == 2'd2) begin
      check_eq("div0_begin", 32'(alu_begin), 32'd0);
    end else begin
      check_eq("arst_reset", 32'(alu_reset), 32'd1);
      check_eq("arst_begin", 32'(alu_begin), 32'd0);
      for (int i = 0; i < nb; i++) begin
        alu_end = 1'($urandom_range(0, 1)); alu_outbus = 8'($urandom);
        @(negedge clk);
        by[i] = alu_inbus;
        check_eq($sformatf("inbus%0d", i), 32'(alu_inbus), 32'(exp_by[i]));
        check_eq($sformatf("begin%0d", i), 32'(alu_begin), (i == 0) ? 32'd1 : 32'd0);
        check_eq($sformatf("alu_reset_ld%0d", i), 32'(alu_reset), 32'd0);
        if (i == 0) check_eq("alu_op", 32'(alu_op), 32'(op));
      end
      alu_end = 1'($urandom_range(0, 1)); alu_outbus = 8'($urandom);
      @(negedge clk);
      alu_end = 1'b0;
      check_eq("inbus_hold", 32'(alu_inbus), 32'(exp_by[nb-1]));
      if (mode == 3) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_alu_reset", 32'(alu_reset), 32'd1);
        check_eq("rst_resp_data", 32'(resp_data), 32'd0);
`ifdef ALU_SEQ_CHECK_EN
        exp_err = 0;
`endif
        return;
      end
      res = alu_model(op, by[0], by[1], by[2]);
      if (mode == 2) res[0] = ~res[0];
      if (mode != 1) begin
        repeat (lat) @(negedge clk);
        alu_end = 1'b1;
        alu_outbus = op[1] ? res[15:8] : res[7:0];
        @(negedge clk);
        if (op[1]) begin alu_outbus = res[7:0]; @(negedge clk); end
        alu_end = 1'b0; alu_outbus = 8'($urandom);
      end
      n = 0;
      while (!resp_valid && n < 300) begin n++; @(negedge clk); end
      if (mode == 1) begin
        check_eq("timeout_cycles", 32'(n), 32'(TMO));
        check_eq("timeout_alu_reset", 32'(alu_reset), 32'd1);
      end
    end

`ifdef ALU_SEQ_CHECK_EN
    if (mode == 2) begin
      exp_st = 2'd3;
      if (exp_err < 255) exp_err++;
    end
`endif
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    check_eq("resp_data", 32'(resp_data), 32'(exp_data));
    check_eq("resp_status", 32'(resp_status), 32'(exp_st));
`ifdef ALU_SEQ_CHECK_EN
    check_eq("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(resp_valid), 32'd1);
      check_eq("stall_data", 32'(resp_data), 32'(exp_data));
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("done_valid", 32'(resp_valid), 32'd0);
    check_eq("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0; alu_outbus = '0; alu_end = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_req_ready", 32'(req_ready), 32'd1);
    check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_resp_data", 32'(resp_data), 32'd0);
    check_eq("reset_resp_status", 32'(resp_status), 32'd0);
    check_eq("reset_alu_reset", 32'(alu_reset), 32'd1);
    check_eq("reset_alu_begin", 32'(alu_begin), 32'd0);
    check_eq("reset_alu_op", 32'(alu_op), 32'd0);
    check_eq("reset_alu_inbus", 32'(alu_inbus), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_alu_reset", 32'(alu_reset), 32'd0);

    run_op(2'd0, 16'h0024, 8'h81, 2, 0, 0);
    run_op(2'd1, 16'h0009, 8'h63, 1, 5, 0);
    run_op(2'd2, 16'h0007, 8'h03, 3, 1, 0);
    run_op(2'd3, 16'h127B, 8'h59, 0, 2, 0);
    run_op(2'd3, 16'h1234, 8'h00, 0, 1, 0);
    run_op(2'd2, 16'h00AB, 8'hCD, 0, 0, 1);
    run_op(2'd2, 16'h0011, 8'h22, 4, 0, 3);
    run_op(2'd0, 16'h00F0, 8'h20, 1, 0, 0);
    run_op(2'd2, 16'h0013, 8'h0B, 2, 0, 2);
    run_op(2'd1, 16'h0000, 8'h01, 17, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] bb;
      bb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(2'($urandom), 16'($urandom), bb, $urandom_range(0, 12), $urandom_range(0, 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_host_sequencer.md
Name: alu_host_sequencer

Overview:
Host-side initiator for the serial-operand ALU. Accepts one operation per request over a valid/ready interface and pulses the ALU reset. It then drives BEGIN/op_code/inbus byte-by-byte, waits for END, collects the 1- or 2-byte result from outbus, and returns it over a valid/ready response interface. Sits between the system controller and the alu instance, replacing the hand-written stimulus sequence.

Parameters:
TIMEOUT_CYC, 255, max cycles in WAIT_END before abort (1..65535)
CNT_W, 16, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request (high only in IDLE)
req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
req_a  input  16  operand A; ADD/SUB/MUL use [7:0]; DIV uses full 16-bit dividend
req_b  input  8  operand B / divisor
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_data  output  16  ADD/SUB {8'h00,res}; MUL {hi,lo}; DIV {quot,rem}
resp_status  output  2  00 OK, 01 timeout, 10 divide-by-zero, 11 check mismatch
alu_reset  output  1  to alu.reset
alu_begin  output  1  to alu.BEGIN
alu_op  output  2  to alu.op_code
alu_inbus  output  8  to alu.inbus
alu_outbus  input  8  from alu.outbus
alu_end  input  1  from alu.END

Behaviour:
- Clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_data 0, resp_status 0, alu_reset 1 (ALU held in reset while the sequencer is in reset), alu_begin 0, alu_op 0, alu_inbus 0.
- States: IDLE, ARST, LD_A, LD_B, LD_C, WAIT_END, CAPT2, RESP.
- IDLE: alu_reset 0, req_ready 1. On req_valid&&req_ready, latch op/a/b and set req_ready 0.
  - If op=DIV and b=0: go to RESP with status 10 and data 0; no ALU activity.
  - Otherwise go to ARST.
- ARST (1 cycle): alu_reset 1.
- LD_A (1 cycle): alu_reset 0, alu_begin 1, alu_op=op, alu_inbus = a[7:0], or a[15:8] for DIV.
- LD_B (1 cycle): alu_begin 0, alu_inbus = b, or a[7:0] for DIV.
  - Next state: LD_C for DIV, else WAIT_END.
- LD_C (DIV only, 1 cycle): alu_inbus = b.
- alu_inbus holds its last value until the next LD_A. alu_op holds until the next request.
- WAIT_END: timeout counter cleared on entry, incremented each cycle.
  - First cycle with alu_end=1:
    - ADD/SUB: capture alu_outbus into resp_data[7:0], clear [15:8], go to RESP with status 00.
    - MUL/DIV: capture into resp_data[15:8], go to CAPT2.
  - Counter reaching TIMEOUT_CYC without alu_end: go to RESP with status 01, data 0, alu_reset 1 for that cycle.
- CAPT2 (1 cycle): capture alu_outbus into resp_data[7:0] (MUL low byte, DIV remainder), go to RESP with status 00.
- RESP: resp_valid 1, data and status stable until resp_valid&&resp_ready. Then return to IDLE with req_ready 1 on the next cycle.
- Minimum request-to-request spacing: ARST+LD_A+LD_B(+LD_C)+ALU latency+capture+1 cycle.
- alu_end asserted in LD_A/LD_B/LD_C is ignored.
- Reset mid-operation: next edge forces IDLE and all reset values; any pending response is discarded.
- Requests while busy are not accepted (req_ready 0). The requester must hold req_valid.

Optional Feature:
ALU_SEQ_CHECK_EN
- Defined: a behavioural reference computes the expected result at request latch: a+b, a−b (8-bit wrap), a*b (16-bit), a/b and a%b (quotient truncated to 8 bits). In RESP, if status would be 00 and resp_data differs from the expected value, status becomes 11. Also adds output err_cnt [7:0], saturating at 255 and cleared by reset, incremented once per mismatching response.
- Undefined: no reference logic, no err_cnt port, status 11 never produced.

Test Plan:
- ADD a=0x24, b=0x81; ALU model returns 0xA5 with END → alu_inbus 0x24 then 0x81, alu_begin high exactly in LD_A; resp_data 0x00A5, status 00.
- SUB a=0x09, b=0x63 → resp_data 0x00A6, status 00. Hold resp_ready low for 5 cycles → resp_valid and data stable, req_ready stays 0.
- MUL a=7, b=3; model outputs 0x00 then 0x15 on consecutive END cycles → resp_data 0x0015. alu_reset high exactly one cycle before alu_begin.
- DIV a=4731 (0x127B), b=89 (0x59) → inbus sequence 0x12, 0x7B, 0x59; model outputs 0x35 then 0x0E → resp_data 0x350E, status 00.
- DIV b=0 → resp_valid within 2 cycles, status 10, alu_begin never asserted. Then a model that never asserts END with TIMEOUT_CYC=20 → status 01 after 20 WAIT_END cycles.
- Assert reset in WAIT_END of a MUL → next cycle state IDLE, req_ready 1, resp_valid 0, alu_reset 1. A following ADD completes correctly. With ALU_SEQ_CHECK_EN and a model corrupting the result → status 11, err_cnt 1.
